slave_read: RTL and testbench
=============================

SLAVE_READ -- requirements
Module: slave_read

Interface
REQ-001 Parameter SRAM_AW, default 14, word-address width of the attached SRAM (64 KiB window).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 ARID_S  input  `AXI_IDS_BITS  read-address ID.
REQ-005 ARADDR_S  input  `AXI_ADDR_BITS  byte address of the first beat.
REQ-006 ARLEN_S  input  `AXI_LEN_BITS  beats minus 1.
REQ-007 ARSIZE_S  input  `AXI_SIZE_BITS  beat size.
REQ-008 ARBURST_S  input  2  0 = FIXED, 1 = INCR.
REQ-009 ARVALID_S  input  1; ARREADY_S  output  1.
REQ-010 RID_S  output  `AXI_IDS_BITS; RDATA_S  output  `AXI_DATA_BITS; RRESP_S  output  2; RLAST_S  output  1; RVALID_S  output  1; RREADY_S  input  1.
REQ-011 sram_cs  output  1; sram_oe  output  1; sram_addr  output  SRAM_AW, word address; sram_dout  input  32, valid one cycle after sram_cs with a stable sram_addr.

Function
REQ-012 FSM states: IDLE, ADDR, WAIT, DATA.
REQ-013 IDLE: ARREADY_S=1, all other outputs at their reset values; ARVALID_S=1 latches ARID/ARADDR/ARLEN/ARSIZE/ARBURST and moves to ADDR.
REQ-014 ADDR: sram_cs=1, sram_oe=1, sram_addr = current byte address [SRAM_AW+1:2]; next state WAIT unconditionally.
REQ-015 WAIT: sram_cs/oe held; sram_dout captured into a data register at the end of the cycle; next state DATA.
REQ-016 DATA: RVALID_S=1, RDATA_S = data register, RID_S = latched ID; RDATA/RID/RRESP/RLAST stay stable while RREADY_S=0.
REQ-017 Latency: AR handshake in cycle T gives first RVALID_S in T+3; each later beat follows its accepting R handshake by 3 cycles.
REQ-018 On RVALID_S&RREADY_S: if it is the last beat, go to IDLE; otherwise update the address and the beat counter, then go to ADDR.
REQ-019 Beat counter is 4-bit and counts up from 0; RLAST_S=1 only in DATA when counter == latched ARLEN (ARLEN=0 gives one beat, ARLEN=15 gives 16).
REQ-020 INCR: address += 4 per beat; the word address wraps modulo 2^SRAM_AW (0xFFFC goes to 0x0000).
REQ-021 FIXED: address is not incremented.
REQ-022 ARBURST=2 or 3 is treated as INCR.
REQ-023 RRESP_S = 2'b00 (OKAY) when latched ARSIZE==2; otherwise 2'b10 (SLVERR) on every beat, with SRAM data still returned.
REQ-024 ARREADY_S=0 in all states except IDLE; the block never accepts a new request while a burst is outstanding.
REQ-025 ARVALID_S arriving mid-burst is ignored until IDLE.

Reset
REQ-026 rst=0 forces IDLE at once, from any state including mid-burst; the pending burst is dropped.
REQ-027 Reset values: ARREADY_S=0, RVALID_S=0, RLAST_S=0, RRESP_S=0, RDATA_S=0, RID_S=0, sram_cs=0, sram_oe=0, sram_addr=0; all latched fields and the counter cleared.
REQ-028 ARREADY_S rises in the first cycle after rst deasserts.

Structure
REQ-029 State enum, RRESP constants (OKAY/SLVERR) and burst-type constants live in shared package axi_pkg; widths come from `AXI_*` defines.
REQ-030 Single module, no sub-module; FSM, address/counter registers and data register are local.

Verification
REQ-031 Single read: ARADDR=0x10, ARLEN=0, SRAM[4]=0xDEADBEEF, RREADY=1 -> RVALID at T+3, RDATA=0xDEADBEEF, RLAST=1, RRESP=0, then ARREADY=1.
REQ-032 INCR burst: ARADDR=0x0, ARLEN=3, SRAM[i]=i+0x100 -> four beats 0x100..0x103, RLAST only on beat 4, RID equals ARID.
REQ-033 Backpressure and FIXED: ARBURST=0, ARLEN=1, RREADY low for 5 cycles per beat -> RDATA held stable, sram_addr constant, two beats.
REQ-034 Wrap: ARADDR=0xFFFC, ARLEN=1, INCR -> sram_addr 0x3FFF then 0x0000.
REQ-035 Error response: ARSIZE=1 -> RRESP=2'b10 on every beat, data returned.
REQ-036 Reset mid-burst: rst=0 during beat 2 of ARLEN=7 -> all outputs at reset values immediately; ARREADY=1 one cycle after release.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read-side definitions: bus widths, FSM state encoding and
// response/burst constants used by the SRAM read slave.
`ifndef AXI_DEFINES_SV
`define AXI_DEFINES_SV
`define AXI_IDS_BITS  8
`define AXI_ADDR_BITS 32
`define AXI_LEN_BITS  4
`define AXI_SIZE_BITS 3
`define AXI_DATA_BITS 32
`endif

package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DATA = 2'd3
  } rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Only full 32-bit beats are served without error.
  localparam logic [`AXI_SIZE_BITS-1:0] SIZE_WORD = `AXI_SIZE_BITS'(2);

endpackage

// File: rtl/slave_read.sv
// AXI read slave in front of a synchronous SRAM: one SRAM access per beat,
// ADDR -> WAIT -> DATA per beat, FIXED or incrementing word addresses.
module slave_read
  import axi_pkg::*;
#(
  parameter int SRAM_AW = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [`AXI_IDS_BITS-1:0]   ARID_S,
  input  logic [`AXI_ADDR_BITS-1:0]  ARADDR_S,
  input  logic [`AXI_LEN_BITS-1:0]   ARLEN_S,
  input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE_S,
  input  logic [1:0]                 ARBURST_S,
  input  logic                       ARVALID_S,
  output logic                       ARREADY_S,
  output logic [`AXI_IDS_BITS-1:0]   RID_S,
  output logic [`AXI_DATA_BITS-1:0]  RDATA_S,
  output logic [1:0]                 RRESP_S,
  output logic                       RLAST_S,
  output logic                       RVALID_S,
  input  logic                       RREADY_S,
  output logic                       sram_cs,
  output logic                       sram_oe,
  output logic [SRAM_AW-1:0]         sram_addr,
  input  logic [31:0]                sram_dout
);

  rd_state_e                  state_q, state_d;
  logic                       arready_q, arready_d;
  logic [`AXI_IDS_BITS-1:0]   id_q, id_d;
  logic [SRAM_AW-1:0]         waddr_q, waddr_d;
  logic [`AXI_LEN_BITS-1:0]   len_q, len_d;
  logic [`AXI_LEN_BITS-1:0]   cnt_q, cnt_d;
  logic [`AXI_SIZE_BITS-1:0]  size_q, size_d;
  logic [1:0]                 burst_q, burst_d;
  logic [`AXI_DATA_BITS-1:0]  data_q, data_d;
  logic                       last_beat;
  logic                       in_data;
  logic                       unused_addr_bits;

  // Byte-lane bits and bits above the SRAM window do not select a word.
  assign unused_addr_bits = ^{ARADDR_S[`AXI_ADDR_BITS-1:SRAM_AW+2], ARADDR_S[1:0]};

  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    waddr_d = waddr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    burst_d = burst_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (ARVALID_S && arready_q) begin
          id_d    = ARID_S;
          waddr_d = ARADDR_S[SRAM_AW+1:2];
          len_d   = ARLEN_S;
          size_d  = ARSIZE_S;
          burst_d = ARBURST_S;
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: state_d = WAIT;
      WAIT: begin
        data_d  = sram_dout;
        state_d = DATA;
      end
      DATA: begin
        if (RREADY_S) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            // Reserved burst encodings behave like INCR; the word address wraps in the window.
            if (burst_q != BURST_FIXED) waddr_d = waddr_q + 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    arready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      id_q      <= '0;
      waddr_q   <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      id_q      <= id_d;
      waddr_q   <= waddr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      data_q    <= data_d;
    end
  end

  assign in_data   = (state_q == DATA);
  assign ARREADY_S = arready_q;
  assign RVALID_S  = in_data;
  assign RDATA_S   = in_data ? data_q : '0;
  assign RID_S     = in_data ? id_q : '0;
  assign RRESP_S   = in_data ? ((size_q == SIZE_WORD) ? RESP_OKAY : RESP_SLVERR) : 2'b00;
  assign RLAST_S   = in_data && last_beat;
  assign sram_cs   = (state_q == ADDR) || (state_q == WAIT);
  assign sram_oe   = sram_cs;
  assign sram_addr = (state_q != IDLE) ? waddr_q : '0;

endmodule

// File: tb/tb_slave_read.sv
// Bench for slave_read: directed bursts plus randomized bursts checked
// against an SRAM array and per-beat expectations computed from the request.
module tb_slave_read;
  import axi_pkg::*;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    ARID_S;
  logic [31:0]   ARADDR_S;
  logic [3:0]    ARLEN_S;
  logic [2:0]    ARSIZE_S;
  logic [1:0]    ARBURST_S;
  logic          ARVALID_S;
  logic          ARREADY_S;
  logic [7:0]    RID_S;
  logic [31:0]   RDATA_S;
  logic [1:0]    RRESP_S;
  logic          RLAST_S;
  logic          RVALID_S;
  logic          RREADY_S;
  logic          sram_cs;
  logic          sram_oe;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_dout;

  logic [31:0]   mem [0:(1<<AW)-1];
  int            vectors = 0;
  int            errs = 0;
  bit            noise_en = 1'b0;

  always #5 clk = ~clk;

  // Synchronous SRAM: data for the addressed word appears one cycle after cs.
  always @(posedge clk) if (sram_cs) sram_dout <= mem[sram_addr];

  slave_read #(.SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_addr(sram_addr), .sram_dout(sram_dout)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_noise();
    if (noise_en) begin
      ARVALID_S = 1'($urandom_range(0, 1));
      ARID_S    = 8'($urandom);
      ARADDR_S  = $urandom;
      ARLEN_S   = 4'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, {ARREADY_S, RVALID_S, RLAST_S, RRESP_S, sram_cs, sram_oe}, 0);
    check_eq({tag, "_rdata"}, RDATA_S, 0);
    check_eq({tag, "_rid"}, RID_S, 0);
    check_eq({tag, "_saddr"}, sram_addr, 0);
  endtask

  // One read burst; abort_beat >= 0 pulls reset while that beat is presented.
  task automatic rd_burst(input logic [7:0] id, input logic [31:0] a, input logic [3:0] l,
                          input logic [2:0] sz, input logic [1:0] b, input int rmode,
                          input int abort_beat);
    int          lat;
    int          hold;
    bit          rr;
    logic [AW-1:0] w;
    logic [31:0] ed;
    lat = 0;
    while (ARREADY_S !== 1'b1 && lat < 20) begin tick(); lat++; end
    check_eq("arready_idle", ARREADY_S, 1);
    if (ARREADY_S !== 1'b1) return;
    ARID_S = id; ARADDR_S = a; ARLEN_S = l; ARSIZE_S = sz; ARBURST_S = b; ARVALID_S = 1'b1;
    tick();
    ARVALID_S = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      w  = AW'((int'(a >> 2) + ((b == BURST_FIXED) ? 0 : i)) % (1 << AW));
      ed = mem[w];
      check_eq("sram_cs", {sram_cs, sram_oe}, 2'b11);
      check_eq("sram_addr", sram_addr, w);
      lat = 1;
      while (RVALID_S !== 1'b1 && lat < 8) begin ar_noise(); tick(); lat++; end
      check_eq("latency", lat, 3);
      if (RVALID_S !== 1'b1) begin ARVALID_S = 1'b0; return; end
      if (i == abort_beat) begin
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        ARVALID_S = 1'b0;
        tick(); tick();
        check_eq("arready_in_rst", ARREADY_S, 0);
        rst = 1'b1;
        tick();
        check_eq("arready_after_rst", ARREADY_S, 1);
        check_eq("rvalid_after_rst", RVALID_S, 0);
        return;
      end
      hold = 0;
      rr   = 1'b0;
      while (!rr && hold < 40) begin
        check_eq("rvalid", RVALID_S, 1);
        check_eq("rdata", RDATA_S, ed);
        check_eq("rid", RID_S, id);
        check_eq("rresp", RRESP_S, (sz == 3'd2) ? 2'b00 : 2'b10);
        check_eq("rlast", RLAST_S, (i == int'(l)));
        check_eq("arready_busy", ARREADY_S, 0);
        case (rmode)
          0:       rr = 1'b1;
          1:       rr = (hold >= 5);
          default: rr = 1'($urandom_range(0, 1));
        endcase
        RREADY_S = rr;
        ar_noise();
        tick();
        hold++;
      end
      RREADY_S = 1'b0;
      if (!rr) begin check_eq("rready_bound", hold, 0); ARVALID_S = 1'b0; return; end
    end
    ARVALID_S = 1'b0;
    check_eq("arready_end", ARREADY_S, 1);
    check_eq("rvalid_end", RVALID_S, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; RREADY_S = 1'b0; ARVALID_S = 1'b0;
    ARID_S = '0; ARADDR_S = '0; ARLEN_S = '0; ARSIZE_S = '0; ARBURST_S = '0;
    for (int k = 0; k < (1 << AW); k++) mem[k] = $urandom;
    tick(); tick();
    check_reset_outputs("por");
    rst = 1'b1;
    tick();
    check_eq("arready_after_por", ARREADY_S, 1);

    mem[4] = 32'hDEADBEEF;
    rd_burst(8'h05, 32'h10, 4'd0, 3'd2, BURST_INCR, 0, -1);
    for (int k = 0; k < 4; k++) mem[k] = 32'h100 + k;
    rd_burst(8'hA3, 32'h0, 4'd3, 3'd2, BURST_INCR, 0, -1);
    rd_burst(8'h3C, 32'h40, 4'd1, 3'd2, BURST_FIXED, 1, -1);
    rd_burst(8'h11, 32'hFFFC, 4'd1, 3'd2, BURST_INCR, 0, -1);
    rd_burst(8'h22, 32'h200, 4'd2, 3'd1, BURST_INCR, 0, -1);
    rd_burst(8'h33, 32'h300, 4'd2, 3'd2, 2'd2, 2, -1);
    rd_burst(8'h44, 32'h3FFF8, 4'd3, 3'd2, 2'd3, 2, -1);
    rd_burst(8'h55, 32'h400, 4'd7, 3'd2, BURST_INCR, 0, 1);
    rd_burst(8'h66, 32'h80, 4'd15, 3'd2, BURST_INCR, 2, -1);

    noise_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rd_burst(8'($urandom), $urandom, 4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2,
               2'($urandom_range(0, 3)), $urandom_range(0, 2), -1);
      ARVALID_S = 1'b0;
      if ($urandom_range(0, 9) == 0) mem[$urandom_range(0, (1 << AW) - 1)] = $urandom;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
